// File: rtl/jc_phase_decoder.sv
// jc_phase_decoder: decodes an 8-bit Johnson counter code into a phase index,
// tracks lock to a monotonically advancing counter and flags faults.
//
// Ports:
//   clk       - clock, rising edge
//   clr       - asynchronous active-low reset
//   en        - sample qualifier; all state holds while low
//   jc_in     - 8-bit Johnson code from the upstream counter
//   err_clr   - request to leave FAULT
//   phase     - decoded phase index 0..15 (0 for an illegal code)
//   phase_oh  - one-hot phase (0 for an illegal code)
//   phase_vld - last sampled code was legal
//   locked    - FSM is in LOCKED
//   err       - sticky fault flag
//   wrap      - one-cycle pulse on a 15->0 advance while locked
//   wrap_cnt  - saturating count of wraps, cleared only by reset
module jc_phase_decoder #(
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  jc_in,
    input  logic        err_clr,
    output logic [3:0]  phase,
    output logic [15:0] phase_oh,
    output logic        phase_vld,
    output logic        locked,
    output logic        err,
    output logic        wrap,
    output logic [15:0] wrap_cnt
);

    localparam int unsigned CODE_W  = 8;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned WCNT_W  = 16;
    localparam logic [IDX_W-1:0]  LOCK_CNT_W = IDX_W'(LOCK_CNT);
    localparam logic [CODE_W-1:0] WRAP_PREV  = 8'h80;

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_acq_cnt;
    logic [CODE_W-1:0]   r_prev;
    logic                r_prev_vld;
    logic [IDX_W-1:0]    r_phase;
    logic [15:0]         r_phase_oh;
    logic                r_phase_vld;
    logic                r_err;
    logic                r_wrap;
    logic [WCNT_W-1:0]   r_wrap_cnt;

    logic                w_legal;
    logic [IDX_W-1:0]    w_idx;
    logic [CODE_W-1:0]   w_succ;
    logic                w_adv;
    logic                w_hold;
    logic                w_skip;

    // Code for a given phase index: low run of ones for 0..7, high run of ones for 8..15.
    function automatic logic [CODE_W-1:0] jc_code(input logic [IDX_W-1:0] idx);
        logic [CODE_W-1:0] hi_mask;
        hi_mask = 8'hFF << idx[2:0];
        return idx[3] ? hi_mask : ~hi_mask;
    endfunction

    // Legality check and index decode by matching against all 16 legal codes.
    always_comb begin
        w_legal = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < 16; i++) begin
            if (jc_in == jc_code(IDX_W'(i))) begin
                w_legal = 1'b1;
                w_idx   = IDX_W'(i);
            end
        end
    end

    // Classification against the previous legal sample; meaningless until prev is valid.
    assign w_succ = {r_prev[6:0], ~r_prev[7]};
    assign w_adv  = r_prev_vld && (jc_in == w_succ);
    assign w_hold = r_prev_vld && (jc_in == r_prev);
    assign w_skip = r_prev_vld && !w_adv && !w_hold;

    // Lock FSM, decode outputs and wrap counting.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= ST_UNLOCK;
            r_acq_cnt   <= '0;
            r_prev      <= '0;
            r_prev_vld  <= 1'b0;
            r_phase     <= '0;
            r_phase_oh  <= '0;
            r_phase_vld <= 1'b0;
            r_err       <= 1'b0;
            r_wrap      <= 1'b0;
            r_wrap_cnt  <= '0;
        end else begin
            r_wrap <= 1'b0;
            if (en) begin
                r_phase     <= w_legal ? w_idx : '0;
                r_phase_oh  <= w_legal ? (16'd1 << w_idx) : '0;
                r_phase_vld <= w_legal;
                if (!w_legal) begin
                    // An illegal code faults from any state, overriding err_clr.
                    r_state <= ST_FAULT;
                    r_err   <= 1'b1;
                end else begin
                    r_prev     <= jc_in;
                    r_prev_vld <= 1'b1;
                    case (r_state)
                        ST_UNLOCK: begin
                            r_state   <= ST_ACQ;
                            r_acq_cnt <= '0;
                        end
                        ST_ACQ: begin
                            if (w_adv) begin
                                r_acq_cnt <= IDX_W'(r_acq_cnt + 4'd1);
                                if (IDX_W'(r_acq_cnt + 4'd1) == LOCK_CNT_W) begin
                                    r_state <= ST_LOCKED;
                                end
                            end else if (w_skip) begin
                                r_acq_cnt <= '0;
                            end
                        end
                        ST_LOCKED: begin
                            if (w_skip) begin
                                r_state <= ST_FAULT;
                                r_err   <= 1'b1;
                            end else if (w_adv && (r_prev == WRAP_PREV)) begin
                                r_wrap <= 1'b1;
                                if (r_wrap_cnt != {WCNT_W{1'b1}}) begin
                                    r_wrap_cnt <= WCNT_W'(r_wrap_cnt + 16'd1);
                                end
                            end
                        end
                        ST_FAULT: begin
                            // Exit invalidates prev so the next legal sample only reloads it.
                            if (err_clr) begin
                                r_state    <= ST_UNLOCK;
                                r_err      <= 1'b0;
                                r_prev_vld <= 1'b0;
                            end
                        end
                        default: r_state <= ST_FAULT;
                    endcase
                end
            end
        end
    end

    assign phase     = r_phase;
    assign phase_oh  = r_phase_oh;
    assign phase_vld = r_phase_vld;
    assign locked    = (r_state == ST_LOCKED);
    assign err       = r_err;
    assign wrap      = r_wrap;
    assign wrap_cnt  = r_wrap_cnt;

endmodule

// File: tb/tb_jc_phase_decoder.sv
// Directed self-checking bench for jc_phase_decoder (LOCK_CNT = 4).
module tb_jc_phase_decoder;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic [7:0]  jc_in;
    logic        err_clr;
    logic [3:0]  phase;
    logic [15:0] phase_oh;
    logic        phase_vld;
    logic        locked;
    logic        err;
    logic        wrap;
    logic [15:0] wrap_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Legal codes in phase order.
    logic [7:0] codes [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                               8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    jc_phase_decoder #(.LOCK_CNT(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .jc_in     (jc_in),
        .err_clr   (err_clr),
        .phase     (phase),
        .phase_oh  (phase_oh),
        .phase_vld (phase_vld),
        .locked    (locked),
        .err       (err),
        .wrap      (wrap),
        .wrap_cnt  (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int ph, input logic vld,
                              input logic lk, input logic er, input logic wr, input int wc);
        logic [15:0] oh;
        oh = vld ? (16'd1 << ph) : 16'd0;
        check({tag, ".phase"},    32'(phase),     32'(ph));
        check({tag, ".phase_oh"}, 32'(phase_oh),  32'(oh));
        check({tag, ".vld"},      32'(phase_vld), 32'(vld));
        check({tag, ".locked"},   32'(locked),    32'(lk));
        check({tag, ".err"},      32'(err),       32'(er));
        check({tag, ".wrap"},     32'(wrap),      32'(wr));
        check({tag, ".wrap_cnt"}, 32'(wrap_cnt),  32'(wc));
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic e, input logic [7:0] j, input logic ec);
        en      = e;
        jc_in   = j;
        err_clr = ec;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr     = 1'b0;
        en      = 1'b0;
        jc_in   = 8'h00;
        err_clr = 1'b0;
        #12;
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        clr = 1'b1;

        // Lock acquisition: first sample only loads prev, then four advances.
        step(1, 8'h00, 0); expect_out("acq0", 0, 1, 0, 0, 0, 0);
        step(1, 8'h01, 0); expect_out("acq1", 1, 1, 0, 0, 0, 0);
        step(1, 8'h03, 0); expect_out("acq2", 2, 1, 0, 0, 0, 0);
        step(1, 8'h07, 0); expect_out("acq3", 3, 1, 0, 0, 0, 0);
        step(1, 8'h0F, 0); expect_out("lock", 4, 1, 1, 0, 0, 0);

        // Advance to the wrap; err_clr while locked must be ignored.
        step(1, 8'h1F, 1); expect_out("errclr_locked", 5, 1, 1, 0, 0, 0);
        for (int i = 6; i < 16; i++) begin
            step(1, codes[i], 0); expect_out("adv", i, 1, 1, 0, 0, 0);
        end
        step(1, 8'h00, 0); expect_out("wrap1", 0, 1, 1, 0, 1, 1);
        step(1, 8'h01, 0); expect_out("post_wrap1", 1, 1, 1, 0, 0, 1);

        // Illegal code, fault wins over err_clr, then legal exit.
        step(1, 8'h05, 0); expect_out("illegal", 0, 0, 0, 1, 0, 1);
        step(1, 8'h05, 1); expect_out("clr_illegal", 0, 0, 0, 1, 0, 1);
        step(1, 8'h03, 1); expect_out("fault_exit", 2, 1, 0, 0, 0, 1);
        step(1, 8'h03, 0); expect_out("relock0", 2, 1, 0, 0, 0, 1);
        step(1, 8'h07, 0); expect_out("relock1", 3, 1, 0, 0, 0, 1);
        step(1, 8'h0F, 0); expect_out("relock2", 4, 1, 0, 0, 0, 1);
        step(1, 8'h1F, 0); expect_out("relock3", 5, 1, 0, 0, 0, 1);
        step(1, 8'h3F, 0); expect_out("relock4", 6, 1, 1, 0, 0, 1);

        // SKIP in ACQ restarts the advance count.
        step(1, 8'h05, 0); expect_out("illegal2", 0, 0, 0, 1, 0, 1);
        step(1, 8'h80, 1); expect_out("fault_exit2", 15, 1, 0, 0, 0, 1);
        step(1, 8'h00, 0); expect_out("skip_a0", 0, 1, 0, 0, 0, 1);
        step(1, 8'h01, 0); expect_out("skip_a1", 1, 1, 0, 0, 0, 1);
        step(1, 8'h03, 0); expect_out("skip_a2", 2, 1, 0, 0, 0, 1);
        step(1, 8'h1F, 0); expect_out("skip_acq", 5, 1, 0, 0, 0, 1);
        step(1, 8'h3F, 0); expect_out("skip_r1", 6, 1, 0, 0, 0, 1);
        step(1, 8'h7F, 0); expect_out("skip_r2", 7, 1, 0, 0, 0, 1);
        step(1, 8'hFF, 0); expect_out("skip_r3", 8, 1, 0, 0, 0, 1);
        step(1, 8'hFE, 0); expect_out("skip_r4", 9, 1, 1, 0, 0, 1);

        // SKIP while locked is a fault even though the code is legal.
        step(1, 8'hF0, 0); expect_out("skip_locked", 12, 1, 0, 1, 0, 1);

        // Relock from 0x80; the 0x80->0x00 advance in ACQ is not a wrap.
        step(1, 8'h80, 1); expect_out("fault_exit3", 15, 1, 0, 0, 0, 1);
        step(1, 8'h80, 0); expect_out("r3_load", 15, 1, 0, 0, 0, 1);
        step(1, 8'h00, 0); expect_out("acq_nowrap", 0, 1, 0, 0, 0, 1);
        step(1, 8'h01, 0); expect_out("r3_a2", 1, 1, 0, 0, 0, 1);
        step(1, 8'h03, 0); expect_out("r3_a3", 2, 1, 0, 0, 0, 1);
        step(1, 8'h07, 0); expect_out("r3_lock", 3, 1, 1, 0, 0, 1);

        // Hold while locked.
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h07, 0); expect_out("hold", 3, 1, 1, 0, 0, 1);
        end

        // Second wrap, then freeze with en=0 (wrap must drop, prev must not move).
        for (int i = 4; i < 16; i++) begin
            step(1, codes[i], 0); expect_out("adv2", i, 1, 1, 0, 0, 1);
        end
        step(1, 8'h00, 0); expect_out("wrap2", 0, 1, 1, 0, 1, 2);
        step(0, 8'($urandom), 0); expect_out("en0_rand", 0, 1, 1, 0, 0, 2);
        step(0, 8'h05, 1);        expect_out("en0_illegal", 0, 1, 1, 0, 0, 2);
        step(0, 8'h03, 0);        expect_out("en0_code", 0, 1, 1, 0, 0, 2);
        step(1, 8'h01, 0);        expect_out("en1_resume", 1, 1, 1, 0, 0, 2);

        // Third wrap to reach wrap_cnt = 3.
        for (int i = 2; i < 16; i++) begin
            step(1, codes[i], 0); expect_out("adv3", i, 1, 1, 0, 0, 2);
        end
        step(1, 8'h00, 0); expect_out("wrap3", 0, 1, 1, 0, 1, 3);

        // Asynchronous reset between edges.
        #2;
        clr = 1'b0;
        #1;
        expect_out("midrst", 0, 0, 0, 0, 0, 0);
        #1;
        clr = 1'b1;
        step(1, 8'h00, 0); expect_out("post_rst0", 0, 1, 0, 0, 0, 0);
        step(1, 8'h01, 0); expect_out("post_rst1", 1, 1, 0, 0, 0, 0);
        step(1, 8'h03, 0); expect_out("post_rst2", 2, 1, 0, 0, 0, 0);
        step(1, 8'h07, 0); expect_out("post_rst3", 3, 1, 0, 0, 0, 0);
        step(1, 8'h0F, 0); expect_out("post_rst_lock", 4, 1, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
